// File: rtl/tank_bullet_if.sv
// Signal bundle between the tank/bullet game-state engine and its environment.
// master drives controls and pixel coordinates; slave is the engine.
interface tank_bullet_if #(
   parameter int NUM_TANKS   = 2,
   parameter int MAX_BULLETS = 8,
   parameter int CW          = 10
);
   localparam int OW = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
   localparam int AW = $clog2(MAX_BULLETS + 1);

   logic                    frame_tick;
   logic [4*NUM_TANKS-1:0]  move;
   logic [NUM_TANKS-1:0]    fire;
   logic [CW-1:0]           x;
   logic [CW-1:0]           y;
   logic [NUM_TANKS*CW-1:0] tank_x;
   logic [NUM_TANKS*CW-1:0] tank_y;
   logic [NUM_TANKS-1:0]    tank_hit;
   logic                    bullet_hit;
   logic [OW-1:0]           bullet_owner;
   logic [AW-1:0]           active_count;
   logic                    spawn_drop;

   modport master (
      output frame_tick, move, fire, x, y,
      input  tank_x, tank_y, tank_hit, bullet_hit, bullet_owner, active_count, spawn_drop
   );

   modport slave (
      input  frame_tick, move, fire, x, y,
      output tank_x, tank_y, tank_hit, bullet_hit, bullet_owner, active_count, spawn_drop
   );
endinterface

// File: rtl/tank_bullet_engine.sv
// Game-state engine for the VGA tank shooter: N clamped tanks, a shared bullet pool,
// per-frame motion/TTL, and a registered per-pixel overlap test for the renderer.
module tank_bullet_engine #(
   parameter int NUM_TANKS    = 2,
   parameter int MAX_BULLETS  = 8,
   parameter int VIDEO_WIDTH  = 640,
   parameter int VIDEO_HEIGHT = 480,
   parameter int SPRITE_SIZE  = 64,
   parameter int BULLET_SIZE  = 8,
   parameter int TANK_STEP    = 3,
   parameter int BULLET_STEP  = 4,
   parameter int BULLET_TTL   = 60,
   parameter int CW           = 10
) (
   input  logic          i_clk,
   input  logic          i_reset,
   tank_bullet_if.slave  bus
);
   localparam int OW = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
   localparam int AW = $clog2(MAX_BULLETS + 1);
   localparam int SW = (MAX_BULLETS > 1) ? $clog2(MAX_BULLETS) : 1;
   localparam logic [CW:0] TX_MAX = (CW+1)'(VIDEO_WIDTH - SPRITE_SIZE);
   localparam logic [CW:0] TY_MAX = (CW+1)'(VIDEO_HEIGHT - SPRITE_SIZE);
   localparam logic [CW:0] BX_MAX = (CW+1)'(VIDEO_WIDTH - BULLET_SIZE);
   localparam logic [CW:0] BY_MAX = (CW+1)'(VIDEO_HEIGHT - BULLET_SIZE);
   localparam logic [CW:0] T_STEP = (CW+1)'(TANK_STEP);
   localparam logic [CW:0] B_STEP = (CW+1)'(BULLET_STEP);
   localparam logic [CW:0] SPR    = (CW+1)'(SPRITE_SIZE);
   localparam logic [CW:0] BSZ    = (CW+1)'(BULLET_SIZE);
   localparam logic [CW:0] OFS    = (CW+1)'(SPRITE_SIZE/2 - BULLET_SIZE/2);

   typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;

   logic [CW-1:0]          r_tank_x [NUM_TANKS];
   logic [CW-1:0]          r_tank_y [NUM_TANKS];
   dir_t                   r_facing [NUM_TANKS];
   logic [NUM_TANKS-1:0]   r_fire_prev, r_pending, r_tank_hit;
   logic [MAX_BULLETS-1:0] r_b_active;
   logic [CW-1:0]          r_b_x [MAX_BULLETS];
   logic [CW-1:0]          r_b_y [MAX_BULLETS];
   dir_t                   r_b_dir [MAX_BULLETS];
   logic [7:0]             r_b_ttl [MAX_BULLETS];
   logic [OW-1:0]          r_b_owner [MAX_BULLETS];
   logic                   r_bullet_hit, r_spawn_drop;
   logic [OW-1:0]          r_bullet_owner;

   logic [CW-1:0]          w_tank_x_nxt [NUM_TANKS];
   logic [CW-1:0]          w_tank_y_nxt [NUM_TANKS];
   dir_t                   w_facing_nxt [NUM_TANKS];
   logic [CW-1:0]          w_b_x_nxt [MAX_BULLETS];
   logic [CW-1:0]          w_b_y_nxt [MAX_BULLETS];
   logic [MAX_BULLETS-1:0] w_b_out, w_b_hit;
   logic [NUM_TANKS-1:0]   w_fire_edge, w_pending_clr, w_pending_nxt, w_tank_hit;
   logic                   w_spawn_req, w_slot_free, w_any_hit;
   logic [OW-1:0]          w_spawn_tank, w_hit_owner;
   logic [SW-1:0]          w_spawn_slot;
   logic [AW-1:0]          w_active_count;
   logic [CW:0]            w_px, w_py;

   // Tank motion with clamping; the vertical axis is evaluated last so it wins facing on diagonals.
   always_comb begin
      for (int t = 0; t < NUM_TANKS; t++) begin
         w_facing_nxt[t] = r_facing[t];
         if (bus.move[4*t+2] && !bus.move[4*t+1]) begin
            w_tank_x_nxt[t] = (({1'b0, r_tank_x[t]} + T_STEP) > TX_MAX) ? TX_MAX[CW-1:0]
                                                                       : r_tank_x[t] + T_STEP[CW-1:0];
            w_facing_nxt[t] = DIR_RIGHT;
         end else if (bus.move[4*t+1] && !bus.move[4*t+2]) begin
            w_tank_x_nxt[t] = ({1'b0, r_tank_x[t]} >= T_STEP) ? r_tank_x[t] - T_STEP[CW-1:0] : '0;
            w_facing_nxt[t] = DIR_LEFT;
         end else begin
            w_tank_x_nxt[t] = r_tank_x[t];
         end
         if (bus.move[4*t+3] && !bus.move[4*t]) begin
            w_tank_y_nxt[t] = (({1'b0, r_tank_y[t]} + T_STEP) > TY_MAX) ? TY_MAX[CW-1:0]
                                                                       : r_tank_y[t] + T_STEP[CW-1:0];
            w_facing_nxt[t] = DIR_DOWN;
         end else if (bus.move[4*t] && !bus.move[4*t+3]) begin
            w_tank_y_nxt[t] = ({1'b0, r_tank_y[t]} >= T_STEP) ? r_tank_y[t] - T_STEP[CW-1:0] : '0;
            w_facing_nxt[t] = DIR_UP;
         end else begin
            w_tank_y_nxt[t] = r_tank_y[t];
         end
      end
   end

   // Bullet next position and out-of-field detection, done in CW+1 bits so nothing wraps.
   always_comb begin
      for (int i = 0; i < MAX_BULLETS; i++) begin
         w_b_x_nxt[i] = r_b_x[i];
         w_b_y_nxt[i] = r_b_y[i];
         w_b_out[i]   = 1'b0;
         case (r_b_dir[i])
            DIR_RIGHT: begin
               w_b_out[i]   = ({1'b0, r_b_x[i]} + B_STEP) > BX_MAX;
               w_b_x_nxt[i] = r_b_x[i] + B_STEP[CW-1:0];
            end
            DIR_LEFT: begin
               w_b_out[i]   = {1'b0, r_b_x[i]} < B_STEP;
               w_b_x_nxt[i] = r_b_x[i] - B_STEP[CW-1:0];
            end
            DIR_DOWN: begin
               w_b_out[i]   = ({1'b0, r_b_y[i]} + B_STEP) > BY_MAX;
               w_b_y_nxt[i] = r_b_y[i] + B_STEP[CW-1:0];
            end
            DIR_UP: begin
               w_b_out[i]   = {1'b0, r_b_y[i]} < B_STEP;
               w_b_y_nxt[i] = r_b_y[i] - B_STEP[CW-1:0];
            end
            default: w_b_out[i] = 1'b1;
         endcase
      end
   end

   // Fire edges, spawn arbitration (descending scans leave the lowest index) and pool occupancy.
   always_comb begin
      w_fire_edge    = bus.fire & ~r_fire_prev;
      w_spawn_req    = (|r_pending) && !bus.frame_tick;
      w_slot_free    = ~&r_b_active;
      w_spawn_tank   = '0;
      w_spawn_slot   = '0;
      w_active_count = '0;
      for (int t = NUM_TANKS-1; t >= 0; t--) begin
         w_spawn_tank = r_pending[t] ? OW'(t) : w_spawn_tank;
      end
      for (int i = MAX_BULLETS-1; i >= 0; i--) begin
         w_spawn_slot   = r_b_active[i] ? w_spawn_slot : SW'(i);
         w_active_count = w_active_count + AW'(r_b_active[i]);
      end
      w_pending_clr = w_spawn_req ? (NUM_TANKS'(1) << w_spawn_tank) : '0;
      w_pending_nxt = (r_pending & ~w_pending_clr) | w_fire_edge;
   end

   // Pixel overlap against registered positions, half-open ranges.
   always_comb begin
      w_px        = {1'b0, bus.x};
      w_py        = {1'b0, bus.y};
      w_hit_owner = '0;
      for (int t = 0; t < NUM_TANKS; t++) begin
         w_tank_hit[t] = (w_px >= {1'b0, r_tank_x[t]}) && (w_px < ({1'b0, r_tank_x[t]} + SPR)) &&
                         (w_py >= {1'b0, r_tank_y[t]}) && (w_py < ({1'b0, r_tank_y[t]} + SPR));
      end
      for (int i = MAX_BULLETS-1; i >= 0; i--) begin
         w_b_hit[i] = r_b_active[i] &&
                      (w_px >= {1'b0, r_b_x[i]}) && (w_px < ({1'b0, r_b_x[i]} + BSZ)) &&
                      (w_py >= {1'b0, r_b_y[i]}) && (w_py < ({1'b0, r_b_y[i]} + BSZ));
         w_hit_owner = w_b_hit[i] ? r_b_owner[i] : w_hit_owner;
      end
      w_any_hit = |w_b_hit;
   end

   // State update: frame ticks move everything from pre-tick values; spawns only happen between ticks.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int t = 0; t < NUM_TANKS; t++) begin
            r_tank_x[t] <= CW'(t * 2 * SPRITE_SIZE);
            r_tank_y[t] <= CW'((VIDEO_HEIGHT - SPRITE_SIZE) / 2);
            r_facing[t] <= DIR_RIGHT;
         end
         for (int i = 0; i < MAX_BULLETS; i++) begin
            r_b_x[i]     <= '0;
            r_b_y[i]     <= '0;
            r_b_dir[i]   <= DIR_RIGHT;
            r_b_ttl[i]   <= 8'd0;
            r_b_owner[i] <= '0;
         end
         r_b_active     <= '0;
         r_fire_prev    <= '0;
         r_pending      <= '0;
         r_tank_hit     <= '0;
         r_bullet_hit   <= 1'b0;
         r_bullet_owner <= '0;
         r_spawn_drop   <= 1'b0;
      end else begin
         r_fire_prev    <= bus.fire;
         r_pending      <= w_pending_nxt;
         r_tank_hit     <= w_tank_hit;
         r_bullet_hit   <= w_any_hit;
         r_bullet_owner <= w_hit_owner;
         r_spawn_drop   <= w_spawn_req && !w_slot_free;
         if (bus.frame_tick) begin
            for (int t = 0; t < NUM_TANKS; t++) begin
               r_tank_x[t] <= w_tank_x_nxt[t];
               r_tank_y[t] <= w_tank_y_nxt[t];
               r_facing[t] <= w_facing_nxt[t];
            end
            for (int i = 0; i < MAX_BULLETS; i++) begin
               if (r_b_active[i]) begin
                  if ((r_b_ttl[i] == 8'd1) || w_b_out[i]) begin
                     r_b_active[i] <= 1'b0;
                  end else begin
                     r_b_x[i]   <= w_b_x_nxt[i];
                     r_b_y[i]   <= w_b_y_nxt[i];
                     r_b_ttl[i] <= r_b_ttl[i] - 8'd1;
                  end
               end
            end
         end else if (w_spawn_req && w_slot_free) begin
            r_b_active[w_spawn_slot] <= 1'b1;
            r_b_x[w_spawn_slot]      <= r_tank_x[w_spawn_tank] + OFS[CW-1:0];
            r_b_y[w_spawn_slot]      <= r_tank_y[w_spawn_tank] + OFS[CW-1:0];
            r_b_dir[w_spawn_slot]    <= r_facing[w_spawn_tank];
            r_b_ttl[w_spawn_slot]    <= 8'(BULLET_TTL);
            r_b_owner[w_spawn_slot]  <= w_spawn_tank;
         end
      end
   end

   for (genvar g = 0; g < NUM_TANKS; g++) begin : g_pos_out
      assign bus.tank_x[CW*g +: CW] = r_tank_x[g];
      assign bus.tank_y[CW*g +: CW] = r_tank_y[g];
   end
   assign bus.tank_hit     = r_tank_hit;
   assign bus.bullet_hit   = r_bullet_hit;
   assign bus.bullet_owner = r_bullet_owner;
   assign bus.active_count = w_active_count;
   assign bus.spawn_drop   = r_spawn_drop;
endmodule
